pass_entry_ctrl: RTL and testbench

//  Password-lock entry controller; the stage directly upstream of the 4-digit 7-segment driver.

---
 rtl/pass_pkg.sv | 25 ++
 rtl/pass_entry_ctrl_if.sv | 21 ++
 rtl/pass_entry_ctrl_timer.sv | 30 +++
 rtl/pass_entry_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pass_entry_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pass_pkg.sv
// Shared constants for the password entry controller: key codes, state encoding, display patterns.
// Pure definitions; no timing or flow-control behaviour lives here.
package pass_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_SET   = 4'hD;

  localparam logic [2:0] ST_ENTRY  = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_OPEN   = 3'd2;
  localparam logic [2:0] ST_FAIL   = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;
  localparam logic [2:0] ST_SET    = 3'd5;

  localparam logic [15:0] PAT_OPEN = 16'hAAAA;
  localparam logic [15:0] PAT_ERR  = 16'hEEEE;
  localparam logic [15:0] PAT_LOCK = 16'hFFFF;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/pass_entry_ctrl_if.sv
// Keypad-in / display-out bundle of the entry controller.
// No backpressure: key strobes are single-cycle and outputs are plain registered levels.
interface pass_entry_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] passvalue;
  logic        unlock;
  logic        alarm;
  logic        set_mode;
  logic [2:0]  fail_cnt;

  modport master (
    output key_valid, key_code,
    input  passvalue, unlock, alarm, set_mode, fail_cnt
  );

  modport slave (
    input  key_valid, key_code,
    output passvalue, unlock, alarm, set_mode, fail_cnt
  );
endinterface

// File: rtl/pass_entry_ctrl_timer.sv
// Down-counter for timed states; load wins over counting, done is high while the count is 0.
// Latency: load takes effect at the next edge; no backpressure.
module pass_timer #(
  parameter int TMR_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - TMR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pass_entry_ctrl.sv
// Password-lock entry FSM: 4-digit buffer, password check, failure/lockout, password change.
// Latency: a key sampled at an edge shows on the registered outputs right after it; unused keys are dropped.
module pass_entry_ctrl
  import pass_pkg::*;
#(
  parameter logic [15:0] DEF_PASS = 16'h1234,
  parameter int          MAX_FAIL = 3,
  parameter int          OPEN_CYC = 50000000,
  parameter int          FAIL_CYC = 25000000,
  parameter int          LOCK_CYC = 250000000,
  parameter int          TMR_W    = 28
) (
  input logic              clk,
  input logic              rst,
  pass_entry_ctrl_if.slave bus
);

  logic [2:0]       state_q, state_d;
  logic [15:0]      entry_q, entry_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      pass_q, pass_d;
  logic [2:0]       fail_q, fail_d;
  logic [15:0]      passvalue_q, passvalue_d;
  logic             unlock_q, unlock_d;
  logic             alarm_q, alarm_d;
  logic             set_mode_q, set_mode_d;
  logic [2:0]       fail_inc;
  logic [2:0]       fail_dest;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic             kv;
  logic [3:0]       kc;

  assign kv = bus.key_valid;
  assign kc = bus.key_code;

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    fail_inc  = fail_q + 3'd1;
    fail_dest = (fail_inc == 3'(MAX_FAIL)) ? ST_LOCKED : ST_FAIL;
    case (state_q)
      ST_ENTRY, ST_SET: begin
        if (kv) begin
          if (is_digit(kc)) begin
            if (cnt_q < 3'd4) begin
              entry_d = {entry_q[11:0], kc};
              cnt_d   = cnt_q + 3'd1;
            end
          end else begin
            case (kc)
              KEY_BKSP: if (cnt_q != 3'd0) begin
                entry_d = {4'h0, entry_q[15:4]};
                cnt_d   = cnt_q - 3'd1;
              end
              KEY_CLR: begin
                entry_d = '0;
                cnt_d   = '0;
              end
              KEY_ENTER: begin
                if (state_q == ST_SET) begin
                  if (cnt_q == 3'd4) pass_d = entry_q;
                  state_d = ST_ENTRY;
                end else if (cnt_q == 3'd4) begin
                  state_d = ST_CHECK;
                end else begin
                  fail_d  = fail_inc;
                  state_d = fail_dest;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_CHECK: begin
        if (entry_q == pass_q) begin
          state_d = ST_OPEN;
          fail_d  = '0;
        end else begin
          fail_d  = fail_inc;
          state_d = fail_dest;
        end
      end
      // Timer expiry outranks any key arriving in the same cycle.
      ST_OPEN: begin
        if (tmr_done || (kv && kc == KEY_CLR)) begin
          state_d = ST_ENTRY;
        end else if (kv && kc == KEY_SET) begin
          state_d = ST_SET;
          entry_d = '0;
          cnt_d   = '0;
        end
      end
      ST_FAIL:   if (tmr_done) state_d = ST_ENTRY;
      ST_LOCKED: if (tmr_done) begin
        state_d = ST_ENTRY;
        fail_d  = '0;
      end
      default: state_d = ST_ENTRY;
    endcase
    if (state_d == ST_ENTRY && state_q != ST_ENTRY) begin
      entry_d = '0;
      cnt_d   = '0;
    end
  end

  // Timer is reloaded only on a transition into a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_OPEN:   begin tmr_load = 1'b1; tmr_val = TMR_W'(OPEN_CYC - 1); end
        ST_FAIL:   begin tmr_load = 1'b1; tmr_val = TMR_W'(FAIL_CYC - 1); end
        ST_LOCKED: begin tmr_load = 1'b1; tmr_val = TMR_W'(LOCK_CYC - 1); end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (state_d)
      ST_OPEN:   passvalue_d = PAT_OPEN;
      ST_FAIL:   passvalue_d = PAT_ERR;
      ST_LOCKED: passvalue_d = PAT_LOCK;
      default:   passvalue_d = entry_d;
    endcase
    unlock_d   = (state_d == ST_OPEN);
    alarm_d    = (state_d == ST_LOCKED);
    set_mode_d = (state_d == ST_SET);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ENTRY;
      entry_q     <= '0;
      cnt_q       <= '0;
      pass_q      <= DEF_PASS;
      fail_q      <= '0;
      passvalue_q <= '0;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
      set_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      passvalue_q <= passvalue_d;
      unlock_q    <= unlock_d;
      alarm_q     <= alarm_d;
      set_mode_q  <= set_mode_d;
    end
  end

  pass_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign bus.passvalue = passvalue_q;
  assign bus.unlock    = unlock_q;
  assign bus.alarm     = alarm_q;
  assign bus.set_mode  = set_mode_q;
  assign bus.fail_cnt  = fail_q;

endmodule

// File: tb/tb_pass_entry_ctrl.sv
// Bench for pass_entry_ctrl: directed scenarios with literal expectations, then random keys,
// all cross-checked every cycle against a digit-queue reference model.
module tb_pass_entry_ctrl;

  localparam int OPEN_C = 8;
  localparam int FAIL_C = 4;
  localparam int LOCK_C = 16;
  localparam int MAXF   = 3;

  localparam int MD_ENTRY = 0, MD_CHECK = 1, MD_OPEN = 2, MD_SET = 3, MD_FAIL = 4, MD_LOCK = 5;

  logic clk;
  logic rst;
  pass_entry_ctrl_if bus();

  pass_entry_ctrl #(
    .DEF_PASS (16'h1234),
    .MAX_FAIL (MAXF),
    .OPEN_CYC (OPEN_C),
    .FAIL_CYC (FAIL_C),
    .LOCK_CYC (LOCK_C),
    .TMR_W    (28)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: mode, entered digits (oldest first), password, failures, cycles spent in mode.
  int m_mode;
  int m_dig[$];
  int m_pass;
  int m_fails;
  int m_dwell;

  function automatic int bufval();
    int v = 0;
    foreach (m_dig[i]) v = (v << 4) | m_dig[i];
    return v;
  endfunction

  function automatic logic [15:0] exp_pv();
    case (m_mode)
      MD_OPEN: return 16'hAAAA;
      MD_FAIL: return 16'hEEEE;
      MD_LOCK: return 16'hFFFF;
      default: return 16'(bufval());
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MD_ENTRY; m_dig.delete(); m_pass = 'h1234; m_fails = 0; m_dwell = 0;
  endtask

  task automatic to_entry();
    m_mode = MD_ENTRY; m_dig.delete();
  endtask

  task automatic failed_attempt();
    m_fails++;
    m_mode  = (m_fails == MAXF) ? MD_LOCK : MD_FAIL;
    m_dwell = 1;
  endtask

  task automatic model_step(input bit kv, input int kc);
    case (m_mode)
      MD_ENTRY, MD_SET: if (kv) begin
        if (kc < 10) begin
          if (m_dig.size() < 4) m_dig.push_back(kc);
        end else if (kc == 'hB) begin
          if (m_dig.size() > 0) void'(m_dig.pop_back());
        end else if (kc == 'hC) begin
          m_dig.delete();
        end else if (kc == 'hA) begin
          if (m_mode == MD_SET) begin
            if (m_dig.size() == 4) m_pass = bufval();
            to_entry();
          end else if (m_dig.size() == 4) m_mode = MD_CHECK;
          else failed_attempt();
        end
      end
      MD_CHECK: begin
        if (bufval() == m_pass) begin m_mode = MD_OPEN; m_dwell = 1; m_fails = 0; end
        else failed_attempt();
      end
      MD_OPEN: begin
        if (m_dwell == OPEN_C || (kv && kc == 'hC)) to_entry();
        else if (kv && kc == 'hD) begin m_mode = MD_SET; m_dig.delete(); end
        else m_dwell++;
      end
      MD_FAIL: if (m_dwell == FAIL_C) to_entry(); else m_dwell++;
      MD_LOCK: if (m_dwell == LOCK_C) begin m_fails = 0; to_entry(); end else m_dwell++;
      default: to_entry();
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] ep;
      logic eu, ea, es;
      logic [2:0] ef;
      ep = exp_pv();
      eu = (m_mode == MD_OPEN);
      ea = (m_mode == MD_LOCK);
      es = (m_mode == MD_SET);
      ef = 3'(m_fails);
      checks++;
      if (bus.passvalue !== ep || bus.unlock !== eu || bus.alarm !== ea ||
          bus.set_mode !== es || bus.fail_cnt !== ef) begin
        errors++;
        $display("FAIL model_cmp t=%0t got pv=%h un=%b al=%b set=%b fc=%0d want pv=%h un=%b al=%b set=%b fc=%0d",
                 $time, bus.passvalue, bus.unlock, bus.alarm, bus.set_mode, bus.fail_cnt,
                 ep, eu, ea, es, ef);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit kv, input logic [3:0] kc);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key_code  = kc;
    @(posedge clk);
    model_step(kv, int'(kc));
    #1;
  endtask

  task automatic press(input logic [3:0] kc);
    cycle(1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0);
  endtask

  task automatic enter_code(input int code);
    for (int i = 3; i >= 0; i--) press(4'((code >> (4 * i)) & 'hF));
    press(4'hA);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    bus.key_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    chk({tag, "_rst_pv"},    int'(bus.passvalue), 0);
    chk({tag, "_rst_flags"}, int'({bus.unlock, bus.alarm, bus.set_mode}), 0);
    chk({tag, "_rst_fail"},  int'(bus.fail_cnt), 0);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    model_reset();
    #12;
    chk("reset_pv", int'(bus.passvalue), 0);
    chk("reset_flags", int'({bus.unlock, bus.alarm, bus.set_mode, bus.fail_cnt}), 0);
    rst = 1'b1;
    chk_en = 1;

    // Correct code, then count the open window.
    press(4'h1); chk("t1_d1", int'(bus.passvalue), 'h0001);
    press(4'h2); chk("t1_d2", int'(bus.passvalue), 'h0012);
    press(4'h3); chk("t1_d3", int'(bus.passvalue), 'h0123);
    press(4'h4); chk("t1_d4", int'(bus.passvalue), 'h1234);
    press(4'hA); chk("t1_check_unlock", int'(bus.unlock), 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (i == 0) chk("t1_open_pv", int'(bus.passvalue), 'hAAAA);
      if (bus.unlock) n++;
    end
    chk("t1_open_cycles", n, 8);
    chk("t1_back_pv", int'(bus.passvalue), 0);

    // Backspace editing and the ignored fifth digit.
    press(4'h1); press(4'h2); press(4'h3); press(4'h5);
    chk("t2_1235", int'(bus.passvalue), 'h1235);
    press(4'hB); chk("t2_bksp", int'(bus.passvalue), 'h0123);
    press(4'h4); chk("t2_1234", int'(bus.passvalue), 'h1234);
    press(4'h9); chk("t2_fifth", int'(bus.passvalue), 'h1234);
    press(4'hA); idle(1);
    chk("t2_open", int'(bus.unlock), 1);
    press(4'hC);
    chk("t5_clr_open", int'({bus.unlock, bus.passvalue}), 0);

    // Three wrong attempts lead to lockout.
    for (int att = 1; att <= 3; att++) begin
      enter_code('h9999);
      idle(1);
      chk("t3_fail_cnt", int'(bus.fail_cnt), (att == 3) ? 3 : att);
      if (att < 3) begin
        n = (bus.passvalue == 16'hEEEE) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
          idle(1);
          if (bus.passvalue == 16'hEEEE) n++;
        end
        chk("t3_err_cycles", n, 4);
      end else begin
        n = bus.alarm ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
          press(4'h5);
          if (bus.alarm) n++;
        end
        chk("t3_lock_cycles", n, 16);
        chk("t3_fail_clear", int'(bus.fail_cnt), 0);
        press(4'hC);
      end
    end

    // Password change and its reversion on reset.
    enter_code('h1234); idle(1);
    press(4'hD);
    chk("t4_set_enter", int'({bus.set_mode, bus.passvalue}), 'h10000);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8);
    chk("t4_set_buf", int'({bus.set_mode, bus.passvalue}), 'h15678);
    press(4'hA);
    chk("t4_set_done", int'({bus.set_mode, bus.passvalue}), 0);
    enter_code('h1234); idle(1);
    chk("t4_old_fails", int'(bus.fail_cnt), 1);
    idle(4);
    enter_code('h5678); idle(1);
    chk("t4_new_opens", int'(bus.unlock), 1);
    press(4'hC);
    async_reset("t4");
    enter_code('h1234); idle(1);
    chk("t4_def_after_rst", int'(bus.unlock), 1);
    press(4'hC);

    // Short entries, then reset while locked.
    press(4'h1); press(4'h2); press(4'hA);
    chk("t5_short", int'({bus.fail_cnt, bus.passvalue}), 'h1EEEE);
    idle(4);
    press(4'hA); idle(4);
    press(4'hA);
    chk("t5_locked", int'(bus.alarm), 1);
    idle(3);
    async_reset("t5");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) enter_code(m_pass);
      else if (r < 5) enter_code(int'($urandom_range(0, 'hFFFF)) & 'h9999);
      else if (r == 5 && $urandom_range(0, 20) == 0) async_reset("rnd");
      else cycle($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
    end

    idle(2);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
